// File: rtl/i2c_defs.sv
// Shared I2C target definitions: FSM states, bus bit meanings and a majority helper.
package i2c_defs;

  localparam int BYTE_W = 8;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: synchroniser, optional majority glitch filter
// (I2C_TARGET_GLITCH_FILTER_EN), then SCL edge and START/STOP detection.
module i2c_line_cond
  import i2c_defs::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic scl_c, sda_c;

  // Idle bus is high, so reset everything to 1 to avoid phantom edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  always_comb begin
    scl_hist_d = {scl_hist_q[1:0], scl_sync_q[SYNC_STAGES-1]};
    sda_hist_d = {sda_hist_q[1:0], sda_sync_q[SYNC_STAGES-1]};
    scl_c      = maj3(scl_hist_q);
    sda_c      = maj3(sda_hist_q);
  end
`else
  always_comb begin
    scl_c = scl_sync_q[SYNC_STAGES-1];
    sda_c = sda_sync_q[SYNC_STAGES-1];
  end
`endif

  always_comb begin
    scl_prev_d = scl_c;
    sda_prev_d = sda_c;
    o_sda      = sda_c;
    o_scl_rise = scl_c & ~scl_prev_q;
    o_scl_fall = ~scl_c & scl_prev_q;
    o_start    = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
    o_stop     = scl_c & scl_prev_q & ~sda_prev_q & sda_c;
  end

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target with 8-bit register pointer and 16-bit data words, exposing writes/reads
// as single-cycle pulses. Optional glitch filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regif
  import i2c_defs::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'b001_0000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_scl,
  inout  wire         io_sda,
  output logic        o_wr_valid,
  output logic [7:0]  o_reg_addr,
  output logic [15:0] o_wr_data,
  output logic        o_rd_req,
  input  logic [15:0] i_rd_data,
  output logic        o_busy
);

  logic sda_c, scl_rise, scl_fall, start, stop;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line_cond (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_scl      (i_scl),
    .i_sda      (io_sda),
    .o_sda      (sda_c),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_start    (start),
    .o_stop     (stop)
  );

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [7:0]          ptr_q, ptr_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic                byte_idx_q, byte_idx_d;
  logic                ack_ph_q, ack_ph_d;
  logic                rw_q, rw_d;
  logic [15:0]         rd_word_q, rd_word_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                wr_valid_q, wr_valid_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                rd_req_q, rd_req_d;
  logic [BYTE_W-1:0]   rx_byte, tx_byte;

  assign io_sda = sda_oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd7;
      shift_q    <= '0;
      ptr_q      <= 8'h00;
      hi_q       <= '0;
      byte_idx_q <= 1'b0;
      ack_ph_q   <= 1'b0;
      rw_q       <= RW_WRITE;
      rd_word_q  <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      hi_q       <= hi_d;
      byte_idx_q <= byte_idx_d;
      ack_ph_q   <= ack_ph_d;
      rw_q       <= rw_d;
      rd_word_q  <= rd_word_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
    end
  end

  assign rx_byte = {shift_q[BYTE_W-2:0], sda_c};
  assign tx_byte = byte_idx_q ? rd_word_q[7:0] : rd_word_q[15:8];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    hi_d       = hi_q;
    byte_idx_d = byte_idx_q;
    ack_ph_d   = ack_ph_q;
    rw_d       = rw_q;
    rd_word_d  = rd_word_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;

    if (rd_req_q) rd_word_d = i_rd_data;
    // Pointer advances after the write pulse so o_reg_addr is the written register.
    if (wr_valid_q) ptr_d = ptr_q + 8'd1;

    case (state_q)
      S_ADDR, S_REG, S_WDATA: begin
        if (scl_rise) begin
          shift_d = rx_byte;
          if (bit_cnt_q != 3'd0) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else if (state_q == S_ADDR) begin
            if (rx_byte[7:1] == DEVICE_ADDR) begin
              state_d = S_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = rx_byte[0];
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end else if (state_q == S_REG) begin
            ptr_d   = rx_byte;
            state_d = S_REG_ACK;
          end else begin
            state_d = S_WDATA_ACK;
          end
        end
      end

      // ack_ph_q splits the ACK bit into "before master samples" and "after".
      S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
        if (scl_fall && !ack_ph_q) begin
          sda_oe_d = 1'b1;
        end else if (scl_rise) begin
          ack_ph_d = 1'b1;
          if (state_q == S_ADDR_ACK && rw_q == RW_READ) begin
            rd_req_d = 1'b1;
          end else if (state_q == S_WDATA_ACK) begin
            if (!byte_idx_q) begin
              hi_d       = shift_q;
              byte_idx_d = 1'b1;
            end else begin
              wr_data_d  = {hi_q, shift_q};
              wr_valid_d = 1'b1;
              byte_idx_d = 1'b0;
            end
          end
        end else if (scl_fall && ack_ph_q) begin
          ack_ph_d  = 1'b0;
          bit_cnt_d = 3'd7;
          sda_oe_d  = 1'b0;
          if (state_q == S_ADDR_ACK && rw_q == RW_READ) begin
            state_d  = S_RDATA;
            sda_oe_d = ~tx_byte[7];
          end else if (state_q == S_REG_ACK) begin
            state_d    = S_WDATA;
            byte_idx_d = 1'b0;
          end else if (state_q == S_ADDR_ACK) begin
            state_d = S_REG;
          end else begin
            state_d = S_WDATA;
          end
        end
      end

      S_RDATA: begin
        if (scl_rise) begin
          if (bit_cnt_q == 3'd0) state_d = S_RDATA_ACK;
          else bit_cnt_d = bit_cnt_q - 3'd1;
        end else if (scl_fall) begin
          sda_oe_d = ~tx_byte[bit_cnt_q];
        end
      end

      S_RDATA_ACK: begin
        if (scl_fall && !ack_ph_q) begin
          sda_oe_d = 1'b0;
        end else if (scl_rise) begin
          if (sda_c == NACK) begin
            state_d = S_IGNORE;
            busy_d  = 1'b0;
          end else begin
            ack_ph_d = 1'b1;
            if (byte_idx_q) begin
              byte_idx_d = 1'b0;
              ptr_d      = ptr_q + 8'd1;
              rd_req_d   = 1'b1;
            end else begin
              byte_idx_d = 1'b1;
            end
          end
        end else if (scl_fall && ack_ph_q) begin
          ack_ph_d  = 1'b0;
          bit_cnt_d = 3'd7;
          state_d   = S_RDATA;
          sda_oe_d  = ~tx_byte[7];
        end
      end

      default: ;
    endcase

    if (start) begin
      state_d    = S_ADDR;
      bit_cnt_d  = 3'd7;
      sda_oe_d   = 1'b0;
      ack_ph_d   = 1'b0;
      byte_idx_d = 1'b0;
    end
    // STOP takes priority if both are ever flagged together.
    if (stop) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
      ack_ph_d = 1'b0;
    end
  end

  assign o_wr_valid = wr_valid_q;
  assign o_reg_addr = ptr_q;
  assign o_wr_data  = wr_data_q;
  assign o_rd_req   = rd_req_q;
  assign o_busy     = busy_q;

endmodule
